result_bus_arbiter: RTL and testbench
=====================================

# result_bus_arbiter

Round-robin controller that shares the ALU's 4:1 32-bit result mux between four requesting arithmetic units. It samples per-unit requests, drives the mux's enable and two select lines, captures the selected result into an output register and presents it on a valid/ready port to the register-file write stage. One result is transferred per grant, and no requester can starve.

## Interface

- WIDTH, 32, result data width; must match the mux data width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req  in  4  req[i] high means unit i has a result pending; held until gnt[i] is seen.
- mux_out  in  WIDTH  output of the shared 4:1 result mux.
- sel_en  out  1  mux enable; high only in SELECT.
- sel_dr  out  1  mux upper select bit (winner index bit 1).
- sel_control  out  1  mux lower select bit (winner index bit 0).
- gnt  out  4  one-hot grant, high for exactly one cycle (SELECT).
- out_data  out  WIDTH  registered result.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready.

## Operation

- Index encoding (sel_dr, sel_control): unit 0 = 00, unit 1 = 01, unit 2 = 10, unit 3 = 11.
- Internal state:
  - 2-bit FSM state: IDLE, SELECT, DRIVE.
  - 2-bit round-robin pointer ptr.
  - 2-bit registered winner w.
- Arbitration function: the winner is the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4, wrap 3→0).
- IDLE:
  - sel_en=0, gnt=0, out_valid=0.
  - If req != 0: w <= winner, go to SELECT. Otherwise stay in IDLE.
- SELECT:
  - sel_en=1, select bits = w, gnt[w]=1.
  - At the clock edge: out_data <= mux_out, ptr <= w+1 (mod 4), go to DRIVE.
  - req is ignored in this state.
- DRIVE:
  - out_valid=1, sel_en=0, gnt=0; select bits hold w; out_data stable.
  - If out_ready=0: stay in DRIVE.
  - If out_ready=1 and req != 0: w <= winner, go to SELECT (back-to-back transfer).
  - If out_ready=1 and req == 0: go to IDLE.
- Requester rule: the granted unit deasserts req[w] in the cycle after gnt. The arbiter never samples req[w] in that same cycle, because SELECT is always followed by DRIVE.
- A unit may withdraw a request before it is granted. Only the req value at the sampling edge (IDLE, or DRIVE with out_ready=1) matters.
- Fairness: a continuously held request is granted within at most 4 grants.

## Timing

- Reset (synchronous): state=IDLE, ptr=0, w=0.
- Reset values of outputs: sel_en=0, sel_dr=0, sel_control=0, gnt=0, out_valid=0, out_data=0.
- Reset mid-operation: reset has priority in every state. An untransferred result in DRIVE is discarded and out_valid=0 in the next cycle.
- Latency:
  - req rises in IDLE at edge N: SELECT in cycle N+1, out_valid=1 in cycle N+2.
  - Sustained throughput with out_ready=1 is 1 result per 2 cycles.
- sel_en, select bits and gnt are Moore outputs decoded from the state and w registers; they have no combinational path from req.
- mux_out must be stable within the SELECT cycle; it is sampled only at the end of SELECT.
- Backpressure: out_ready low holds DRIVE indefinitely, with out_data and out_valid unchanged and no grants issued.
- Simultaneous events:
  - All four requests high right after reset: grant order is 0,1,2,3,0,...
  - out_ready rises together with new requests in DRIVE: the handshake completes and the next SELECT begins in the following cycle (no bubble).

## Test plan

- Reset: hold reset 2 cycles with req=1111 → all outputs 0 and gnt=0 throughout; the first grant goes to unit 0.
- Single request:
  - Stimulus: req=0100; the bench mux model returns 0xCAFE0002 for index 2.
  - Required response: next cycle sel_en=1, sel_dr=1, sel_control=0, gnt=0100; the cycle after, out_valid=1 and out_data=0xCAFE0002.
- Full load:
  - Stimulus: all req held, each unit dropping req for one cycle after its gnt; out_ready=1.
  - Required response: gnt sequence 0001, 0010, 0100, 1000, 0001, one grant every 2 cycles; out_data matches each unit's value.
- Pointer wrap:
  - Stimulus: grant unit 1 (ptr becomes 2), then assert req=0011.
  - Required response: unit 0 is granted before unit 1.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles in DRIVE while req=1000.
  - Required response: out_data and out_valid stable, gnt=0; unit 3 is granted one cycle after out_ready rises.
- Reset mid-DRIVE:
  - Stimulus: assert reset while out_valid=1.
  - Required response: out_valid=0 and out_data=0 next cycle, state IDLE, and the previously pending requests are re-arbitrated starting from unit 0.

Source files
------------

// File: rtl/result_bus_arbiter.sv
// Round-robin owner of the shared 4:1 ALU result mux: grants one unit per
// transfer, captures the muxed result and offers it on a valid/ready port.
module result_bus_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] mux_out,
    output logic             sel_en,
    output logic             sel_dr,
    output logic             sel_control,
    output logic [3:0]       gnt,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        DRIVE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       w_q, w_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       winner;

    // First requester found scanning upward from the pointer, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign winner = rr_pick(req, ptr_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            w_q     <= 2'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        w_d       = w_q;
        data_d    = data_q;
        sel_en    = 1'b0;
        gnt       = 4'b0000;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    w_d     = winner;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                // req is deliberately not looked at here; the winner drops it next cycle.
                sel_en  = 1'b1;
                gnt     = 4'b0001 << w_q;
                data_d  = mux_out;
                ptr_d   = w_q + 2'd1;
                state_d = DRIVE;
            end
            DRIVE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (|req) begin
                        w_d     = winner;
                        state_d = SELECT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_dr      = w_q[1];
    assign sel_control = w_q[0];
    assign out_data    = data_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Scoreboard bench for result_bus_arbiter: directed stimulus pushes expected
// grants and results; a negedge monitor pops and compares them.
module tb_result_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] mux_out;
    logic        sel_en, sel_dr, sel_control;
    logic [3:0]  gnt;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    logic [31:0] base;

    typedef struct {
        logic [3:0] g;
        int         gap;   // cycles since the previous grant, 0 = don't care
    } gexp_t;

    gexp_t       gq[$];
    logic [31:0] dq[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_gnt_cyc = 0;

    result_bus_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .mux_out    (mux_out),
        .sel_en     (sel_en),
        .sel_dr     (sel_dr),
        .sel_control(sel_control),
        .gnt        (gnt),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    // Mux model: each unit's result is the current base tagged with its index.
    assign mux_out = base | {30'd0, sel_dr, sel_control};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input logic [3:0] g, input int gap);
        gexp_t e;
        e.g   = g;
        e.gap = gap;
        gq.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        gexp_t e;
        cyc++;
        if (!reset && gnt != 4'b0000) begin
            if (gq.size() == 0) begin
                chk("unexpected_gnt", {28'd0, gnt}, 32'd0);
            end else begin
                e = gq.pop_front();
                chk("gnt", {28'd0, gnt}, {28'd0, e.g});
                chk("sel_en_in_select", {31'd0, sel_en}, 32'd1);
                chk("sel_bits_match_gnt", {28'd0, 4'b0001 << {sel_dr, sel_control}}, {28'd0, e.g});
                if (e.gap != 0)
                    chk("gnt_spacing", cyc - last_gnt_cyc, e.gap);
            end
            last_gnt_cyc = cyc;
        end
        if (!reset && out_valid && out_ready) begin
            if (dq.size() == 0)
                chk("unexpected_xfer", out_data, 32'hFFFF_FFFF);
            else
                chk("xfer_data", out_data, dq.pop_front());
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [3:0] last;

        // Reset held two cycles with all requests up
        reset     = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b1;
        base      = 32'h1111_0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_sel_en", {31'd0, sel_en}, 32'd0);
            chk("rst_sel_bits", {30'd0, sel_dr, sel_control}, 32'd0);
            chk("rst_gnt", {28'd0, gnt}, 32'd0);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_data", out_data, 32'd0);
        end

        // Full load: each unit drops req for the cycle after its grant
        reset = 1'b0;
        exp_gnt(4'b0001, 0); dq.push_back(32'h1111_0000);
        exp_gnt(4'b0010, 2); dq.push_back(32'h1111_0001);
        exp_gnt(4'b0100, 2); dq.push_back(32'h1111_0002);
        exp_gnt(4'b1000, 2); dq.push_back(32'h1111_0003);
        exp_gnt(4'b0001, 2); dq.push_back(32'h1111_0000);
        last = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            req  = 4'b1111 & ~last;
            last = gnt;
            tick();
        end
        req = 4'b0000;
        tick();

        // Single request from unit 2
        base = 32'hCAFE_0000;
        req  = 4'b0100;
        exp_gnt(4'b0100, 0); dq.push_back(32'hCAFE_0002);
        tick();
        chk("single_sel_en", {31'd0, sel_en}, 32'd1);
        chk("single_sel_dr", {31'd0, sel_dr}, 32'd1);
        chk("single_sel_control", {31'd0, sel_control}, 32'd0);
        chk("single_gnt", {28'd0, gnt}, 32'h4);
        req = 4'b0000;
        tick();
        chk("single_out_valid", {31'd0, out_valid}, 32'd1);
        chk("single_out_data", out_data, 32'hCAFE_0002);
        tick();

        // Pointer wrap: grant unit 1 so ptr=2, then units 0 and 1 compete
        base = 32'h0BAD_0000;
        req  = 4'b0010;
        exp_gnt(4'b0010, 0); dq.push_back(32'h0BAD_0001);
        tick();
        req = 4'b0000;
        tick();
        tick();
        req = 4'b0011;
        exp_gnt(4'b0001, 0); dq.push_back(32'h0BAD_0000);
        exp_gnt(4'b0010, 2); dq.push_back(32'h0BAD_0001);
        tick();
        req = 4'b0010;
        tick();
        tick();
        req = 4'b0000;
        tick();
        tick();

        // Backpressure with unit 3 requesting throughout
        base = 32'hBEEF_0000;
        req  = 4'b1000;
        exp_gnt(4'b1000, 0); dq.push_back(32'hBEEF_0003);
        tick();
        out_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data", out_data, 32'hBEEF_0003);
            chk("bp_gnt", {28'd0, gnt}, 32'd0);
            tick();
        end
        chk("bp_still_valid", {31'd0, out_valid}, 32'd1);
        base      = 32'hF00D_0000;
        out_ready = 1'b1;
        exp_gnt(4'b1000, 7); dq.push_back(32'hF00D_0003);
        tick();
        req = 4'b0000;
        tick();
        tick();

        // Reset mid-DRIVE with ptr=2 and units 0 and 2 still pending
        base = 32'h5A5A_0000;
        req  = 4'b0010;
        exp_gnt(4'b0010, 0);
        tick();
        out_ready = 1'b0;
        req       = 4'b0101;
        tick();
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_out_data", out_data, 32'h5A5A_0001);
        reset = 1'b1;
        tick();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_sel_en", {31'd0, sel_en}, 32'd0);
        chk("mid_rst_gnt", {28'd0, gnt}, 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        exp_gnt(4'b0001, 0); dq.push_back(32'h5A5A_0000);
        exp_gnt(4'b0100, 2); dq.push_back(32'h5A5A_0002);
        tick();
        req = 4'b0100;
        tick();
        tick();
        req = 4'b0000;
        tick();
        tick();
        chk("end_idle_out_valid", {31'd0, out_valid}, 32'd0);
        tick();

        chk("gnt_queue_drained", gq.size(), 32'd0);
        chk("data_queue_drained", dq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
